led_blinker_bank: RTL and testbench



---
 rtl/led_blinker_bank.sv | 134 +++++++++++++
 tb/tb_led_blinker_bank.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_blinker_bank.sv
// rtl/led_blinker_bank.sv - bank of NCH LED drivers (off/on/blink/one-shot) sharing one tick prescaler
// Build option: LED_BANK_FAST_SIM_EN forces the prescaler divide to 4 for simulation.
module led_blinker_bank #(
    parameter int NCH     = 4,
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 1000,
    parameter int PER_W   = 12
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic [2*NCH-1:0]       mode,
    input  logic [PER_W*NCH-1:0]   half_per,
    input  logic [NCH-1:0]         trig,
    input  logic                   restart,
    output logic                   tick,
    output logic [NCH-1:0]         led
);

`ifdef LED_BANK_FAST_SIM_EN
    localparam int DIV = 4;
`else
    localparam int DIV = CLK_HZ / TICK_HZ;
`endif
    localparam int PCW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        M_OFF     = 2'b00,
        M_ON      = 2'b01,
        M_BLINK   = 2'b10,
        M_ONESHOT = 2'b11
    } mode_e;

    logic [PCW-1:0] pcnt_q, pcnt_d;
    logic           tick_q, tick_d;

    always_comb begin
        pcnt_d = pcnt_q;
        tick_d = 1'b0;
        if (restart) begin
            pcnt_d = '0;
        end else begin
            tick_d = (pcnt_q == PCW'(DIV - 1));
            pcnt_d = tick_d ? '0 : pcnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pcnt_q <= '0;
            tick_q <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        mode_e            mode_q, mode_d, mode_in;
        logic [PER_W-1:0] cnt_q, cnt_d, hp_raw, hp_m1;
        logic             led_q, led_d;

        assign mode_in = mode_e'(mode[2*g +: 2]);
        assign hp_raw  = half_per[PER_W*g +: PER_W];
        // half_per of 0 behaves as 1, so the terminal count is 0 in both cases
        assign hp_m1   = (hp_raw == '0) ? '0 : hp_raw - 1'b1;

        always_comb begin
            mode_d = mode_q;
            cnt_d  = cnt_q;
            led_d  = led_q;
            if (restart) begin
                cnt_d = '0;
                if (mode_q == M_BLINK)   led_d = 1'b1;
                if (mode_q == M_ONESHOT) led_d = 1'b0;
            end else if (mode_in != mode_q) begin
                mode_d = mode_in;
                cnt_d  = '0;
                led_d  = (mode_in == M_ON) || (mode_in == M_BLINK);
            end else begin
                case (mode_q)
                    M_OFF: begin
                        led_d = 1'b0;
                        cnt_d = '0;
                    end
                    M_ON: begin
                        led_d = 1'b1;
                        cnt_d = '0;
                    end
                    M_BLINK: begin
                        if (tick_q) begin
                            if (cnt_q >= hp_m1) begin
                                cnt_d = '0;
                                led_d = ~led_q;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                    end
                    M_ONESHOT: begin
                        if (trig[g]) begin
                            led_d = 1'b1;
                            cnt_d = '0;
                        end else if (led_q && tick_q) begin
                            if (cnt_q >= hp_m1) begin
                                led_d = 1'b0;
                                cnt_d = '0;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                mode_q <= M_OFF;
                cnt_q  <= '0;
                led_q  <= 1'b0;
            end else begin
                mode_q <= mode_d;
                cnt_q  <= cnt_d;
                led_q  <= led_d;
            end
        end

        assign led[g] = led_q;
    end

endmodule

// File: tb/tb_led_blinker_bank.sv
// tb/tb_led_blinker_bank.sv - directed self-checking bench for led_blinker_bank (prescaler divide of 4)
module tb_led_blinker_bank;
    localparam int NCH   = 4;
    localparam int PER_W = 12;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [2*NCH-1:0]     mode;
    logic [PER_W*NCH-1:0] half_per;
    logic [NCH-1:0]       trig;
    logic                 restart;
    logic                 tick;
    logic [NCH-1:0]       led;

    int checks   = 0;
    int failures = 0;

    led_blinker_bank #(.NCH(NCH), .CLK_HZ(4), .TICK_HZ(1), .PER_W(PER_W)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .mode(mode), .half_per(half_per),
        .trig(trig), .restart(restart), .tick(tick), .led(led)
    );

    always #5 clk = ~clk;

    task automatic set_hp(input int ch, input int v);
        half_per[PER_W*ch +: PER_W] = v[PER_W-1:0];
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic wait_for(input int ch, input logic val, input int max, input string name);
        int n;
        n = 0;
        while (led[ch] !== val && n < max) begin
            @(negedge clk);
            n++;
        end
        if (led[ch] !== val) begin
            checks++; failures++;
            $display("FAIL %s timeout: led[%0d]=%b wanted %b", name, ch, led[ch], val);
        end
    endtask

    task automatic measure(input int ch, input logic val, input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (led[ch] === val && n < max);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 8'b10101010; trig = '0; restart = 1'b0;
        for (int c = 0; c < NCH; c++) set_hp(c, 3);
        repeat (3) @(negedge clk);
        checks++;
        if (led !== 4'b0000 || tick !== 1'b0) begin
            failures++; $display("FAIL reset_state: led=%b tick=%b wanted 0000/0", led, tick);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (led !== 4'b1111) begin
                    failures++; $display("FAIL reset_entry: led=%b wanted 1111", led);
                end
            end
            checks++;
            if (tick !== (k % 4 == 0)) begin
                failures++; $display("FAIL reset_tick k=%0d: tick=%b wanted %b", k, tick, (k % 4 == 0));
            end
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (led !== 4'b0000 || tick !== 1'b0) begin
            failures++; $display("FAIL reset_async: led=%b tick=%b wanted 0000/0", led, tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_blink();
        int n;
        mode = 8'b00000010;
        set_hp(0, 3);
        repeat (2) @(negedge clk);
        pulse_restart();
        checks++;
        if (led[0] !== 1'b1) begin
            failures++; $display("FAIL blink_restart: led0=%b wanted 1", led[0]);
        end
        wait_for(0, 1'b0, 40, "blink_first");
        measure(0, 1'b0, 100, n);
        checks++;
        if (n != 12) begin failures++; $display("FAIL blink_low: got %0d cycles wanted 12", n); end
        measure(0, 1'b1, 100, n);
        checks++;
        if (n != 12) begin failures++; $display("FAIL blink_high: got %0d cycles wanted 12", n); end
        repeat (5) @(negedge clk);
        set_hp(0, 1);
        n = 0;
        while (led[0] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 3) begin failures++; $display("FAIL blink_lower: got %0d cycles wanted 3", n); end
    endtask

    task automatic test_solid();
        checks++;
        if (led[1] !== 1'b0) begin failures++; $display("FAIL solid_pre: led1=%b wanted 0", led[1]); end
        mode = 8'b00000110;
        @(negedge clk);
        checks++;
        if (led[1] !== 1'b1) begin failures++; $display("FAIL solid_on: led1=%b wanted 1", led[1]); end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (led[1] !== 1'b1) begin failures++; $display("FAIL solid_hold1 k=%0d: led1=%b wanted 1", k, led[1]); end
        end
        mode = 8'b00000010;
        @(negedge clk);
        checks++;
        if (led[1] !== 1'b0) begin failures++; $display("FAIL solid_off: led1=%b wanted 0", led[1]); end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (led[1] !== 1'b0) begin failures++; $display("FAIL solid_hold0 k=%0d: led1=%b wanted 0", k, led[1]); end
        end
    endtask

    task automatic wait_tick(input string name);
        int n;
        n = 0;
        while (tick !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (tick !== 1'b1) begin
            checks++; failures++;
            $display("FAIL %s timeout: tick=%b wanted 1", name, tick);
        end
    endtask

    task automatic test_oneshot();
        int n;
        mode = 8'b00110000;
        set_hp(2, 5);
        trig = 4'b1000;
        repeat (2) @(negedge clk);
        trig = '0;
        @(negedge clk);
        checks++;
        if (led[3:2] !== 2'b00) begin failures++; $display("FAIL oneshot_idle: led[3:2]=%b wanted 00", led[3:2]); end
        wait_tick("oneshot_tick");
        trig[2] = 1'b1;
        @(negedge clk);
        trig = '0;
        checks++;
        if (led[2] !== 1'b1) begin failures++; $display("FAIL oneshot_fire: led2=%b wanted 1", led[2]); end
        measure(2, 1'b1, 50, n);
        checks++;
        if (n != 20) begin failures++; $display("FAIL oneshot_width: got %0d cycles wanted 20", n); end
        wait_tick("retrig_tick");
        trig[2] = 1'b1;
        @(negedge clk);
        trig = '0;
        repeat (11) @(negedge clk);
        checks++;
        if (tick !== 1'b1 || led[2] !== 1'b1) begin
            failures++; $display("FAIL retrig_phase: tick=%b led2=%b wanted 1/1", tick, led[2]);
        end
        trig[2] = 1'b1;
        @(negedge clk);
        trig = '0;
        measure(2, 1'b1, 50, n);
        checks++;
        if (n != 20) begin failures++; $display("FAIL retrig_width: got %0d cycles wanted 20", n); end
    endtask

    task automatic test_align();
        int t0[8], t3[8];
        int n0, n3;
        logic [NCH-1:0] prev;
        for (int i = 0; i < 8; i++) begin t0[i] = -1; t3[i] = -2; end
        n0 = 0; n3 = 0;
        mode = 8'b10000010;
        set_hp(0, 2);
        set_hp(3, 4);
        repeat (2) @(negedge clk);
        pulse_restart();
        checks++;
        if (led[0] !== 1'b1 || led[3] !== 1'b1) begin
            failures++; $display("FAIL align_rise: led0=%b led3=%b wanted 1/1", led[0], led[3]);
        end
        prev = led;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (led[0] !== prev[0] && n0 < 8) begin t0[n0] = k; n0++; end
            if (led[3] !== prev[3] && n3 < 8) begin t3[n3] = k; n3++; end
            prev = led;
        end
        checks++;
        if (n0 != 4 || n3 != 2) begin failures++; $display("FAIL align_count: ch0=%0d ch3=%0d wanted 4/2", n0, n3); end
        checks++;
        if (t0[1] - t0[0] != 8 || t0[2] - t0[1] != 8 || t0[3] - t0[2] != 8) begin
            failures++; $display("FAIL align_ch0: toggles %0d %0d %0d %0d wanted spacing 8", t0[0], t0[1], t0[2], t0[3]);
        end
        checks++;
        if (t3[0] != t0[1] || t3[1] != t0[3]) begin
            failures++; $display("FAIL align_ch3: toggles %0d %0d wanted %0d %0d", t3[0], t3[1], t0[1], t0[3]);
        end
    endtask

    task automatic test_edge();
        int n;
        mode = 8'b00000010;
        set_hp(0, 0);
        repeat (2) @(negedge clk);
        pulse_restart();
        wait_for(0, 1'b0, 20, "hp0_first");
        measure(0, 1'b0, 20, n);
        checks++;
        if (n != 4) begin failures++; $display("FAIL hp0_low: got %0d cycles wanted 4", n); end
        measure(0, 1'b1, 20, n);
        checks++;
        if (n != 4) begin failures++; $display("FAIL hp0_high: got %0d cycles wanted 4", n); end
        set_hp(0, 4095);
        pulse_restart();
        wait_for(0, 1'b0, 17000, "hpmax_first");
        measure(0, 1'b0, 20000, n);
        checks++;
        if (n != 16380) begin failures++; $display("FAIL hpmax_low: got %0d cycles wanted 16380", n); end
    endtask

    task automatic test_reset_oneshot();
        bit bad;
        mode = 8'b00110000;
        set_hp(2, 5);
        repeat (2) @(negedge clk);
        trig[2] = 1'b1;
        @(negedge clk);
        trig = '0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (led !== 4'b0000) begin failures++; $display("FAIL rst_oneshot_async: led=%b wanted 0000", led); end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (led[2] !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin failures++; $display("FAIL rst_oneshot_gone: led2 went high wanted 0"); end
    endtask

    initial begin
        test_reset();
        test_blink();
        test_solid();
        test_oneshot();
        test_align();
        test_edge();
        test_reset_oneshot();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
